// File: rtl/array_table_pkg.sv
// Shared types and sizes for the shared lookup-table arbiter.
package array_table_pkg;
  localparam int ENT_W = 4;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  typedef logic [ENT_W-1:0] array_t [DEPTH-1:0];

  // Identity table: entry[i] = i
  localparam array_t INIT_IDENT = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
endpackage

// File: rtl/array_table_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; lowest set bit at or above ptr wins, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt
);
  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] back;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   first;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NREQ-1:0];
    first = rot & (~rot + 1'b1);
    back  = {{NREQ{1'b0}}, first} << ptr;
    gnt   = back[NREQ-1:0] | back[2*NREQ-1:NREQ];
  end
endmodule

// File: rtl/array_table_arbiter.sv
// Round-robin shared 8x4 lookup table with registered response.
// ARRAY_TABLE_WRITE_EN adds a write port and makes the table a register file.
module array_table_arbiter
  import array_table_pkg::*;
#(
  parameter int     NREQ = 4,
  parameter array_t INIT = INIT_IDENT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [IDX_W*NREQ-1:0]    idx,
  output logic [NREQ-1:0]          gnt,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [ENT_W-1:0]         rsp_data
`ifdef ARRAY_TABLE_WRITE_EN
  ,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [ENT_W-1:0]         wr_data
`endif
);
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0]  pick;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [IDX_W-1:0] sel_idx;
  logic             vld_q;
  logic [PW-1:0]    id_q;
  logic [ENT_W-1:0] data_q;
  array_t           tbl;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick)
  );

  // A grant raised during reset must not produce a response.
  assign gnt = rst ? '0 : pick;

  always_comb begin
    win     = '0;
    sel_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        win     = PW'(k);
        sel_idx = idx[IDX_W*k +: IDX_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      vld_q  <= 1'b0;
      id_q   <= '0;
      data_q <= '0;
    end else begin
      vld_q <= |gnt;
      if (|gnt) begin
        ptr    <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
        id_q   <= win;
        data_q <= tbl[sel_idx];
      end
    end
  end

`ifdef ARRAY_TABLE_WRITE_EN
  // Lookup reads tbl before this edge's write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (rst)        tbl <= INIT;
    else if (wr_en) tbl[wr_idx] <= wr_data;
  end
`else
  assign tbl = INIT;
`endif

  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
endmodule

// File: tb/tb_array_table_arbiter.sv
// Randomized + directed bench for array_table_arbiter; two instances (identity INIT, NREQ=4; custom INIT, NREQ=3).
module tb_array_table_arbiter;
  import array_table_pkg::*;

  localparam int N0 = 4;
  localparam int N1 = 3;
  localparam array_t INIT1 = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  logic clk = 1'b0;
  logic rst;
  logic [N0-1:0]   req0;
  logic [3*N0-1:0] idx0;
  logic [N0-1:0]   gnt0;
  logic            rv0;
  logic [1:0]      id0;
  logic [3:0]      d0;
  logic [N1-1:0]   req1;
  logic [3*N1-1:0] idx1;
  logic [N1-1:0]   gnt1;
  logic            rv1;
  logic [1:0]      id1;
  logic [3:0]      d1;
  logic            wr_en;
  logic [2:0]      wr_idx;
  logic [3:0]      wr_data;

  array_table_arbiter #(.NREQ(N0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .idx(idx0), .gnt(gnt0),
    .rsp_valid(rv0), .rsp_id(id0), .rsp_data(d0)
`ifdef ARRAY_TABLE_WRITE_EN
    , .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
`endif
  );

  array_table_arbiter #(.NREQ(N1), .INIT(INIT1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .idx(idx1), .gnt(gnt1),
    .rsp_valid(rv1), .rsp_id(id1), .rsp_data(d1)
`ifdef ARRAY_TABLE_WRITE_EN
    , .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state per instance
  int m_tbl [2][8];
  int m_ptr [2];
  int m_vld [2];
  int m_id  [2];
  int m_dat [2];
  int n_of  [2] = '{N0, N1};

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input int n, input int p, input int rq);
    for (int o = 0; o < n; o++) begin
      int k;
      k = (p + o) % n;
      if (((rq >> k) & 1) != 0) return k;
    end
    return -1;
  endfunction

  function automatic int init_val(input int d, input int i);
    return (d == 0) ? i : 15 - i;
  endfunction

  // One clock: check combinational grant, advance model at the edge, check response.
  task automatic step();
    int w [2];
    int rq[2];
    int ix[2];
    rq[0] = int'(req0); rq[1] = int'(req1);
    ix[0] = int'(idx0); ix[1] = int'(idx1);
    #1;
    for (int d = 0; d < 2; d++) w[d] = rst ? -1 : pick(n_of[d], m_ptr[d], rq[d]);
    chk("gnt0", int'(gnt0), (w[0] < 0) ? 0 : (1 << w[0]));
    chk("gnt1", int'(gnt1), (w[1] < 0) ? 0 : (1 << w[1]));
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) m_tbl[d][i] = init_val(d, i);
        m_ptr[d] = 0; m_vld[d] = 0; m_id[d] = 0; m_dat[d] = 0;
      end else begin
        if (w[d] >= 0) begin
          m_vld[d] = 1;
          m_id[d]  = w[d];
          m_dat[d] = m_tbl[d][(ix[d] >> (3 * w[d])) & 7];
          m_ptr[d] = (w[d] + 1) % n_of[d];
        end else begin
          m_vld[d] = 0;
        end
`ifdef ARRAY_TABLE_WRITE_EN
        if (wr_en) m_tbl[d][int'(wr_idx)] = int'(wr_data);
`endif
      end
    end
    chk("rsp_valid0", int'(rv0), m_vld[0]);
    chk("rsp_id0",    int'(id0), m_id[0]);
    chk("rsp_data0",  int'(d0),  m_dat[0]);
    chk("rsp_valid1", int'(rv1), m_vld[1]);
    chk("rsp_id1",    int'(id1), m_id[1]);
    chk("rsp_data1",  int'(d1),  m_dat[1]);
  endtask

  initial begin
    int exp2 [5] = '{7, 6, 5, 4, 7};
    rst = 1'b1; req0 = '0; idx0 = '0; req1 = '0; idx1 = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_tbl[d][i] = init_val(d, i);
      m_ptr[d] = 0; m_vld[d] = 0; m_id[d] = 0; m_dat[d] = 0;
    end
    step(); step();
    chk("reset_valid", int'(rv0), 0);
    rst = 1'b0;

    // Single requester, identity table
    req0 = 4'b0001; idx0 = 12'd5;
    step();
    chk("t1_valid", int'(rv0), 1);
    chk("t1_data",  int'(d0),  5);
    req0 = '0;
    rst = 1'b1; step(); rst = 1'b0;

    // All four requesting: rotation 0,1,2,3,0
    req0 = 4'hF; idx0 = {3'd4, 3'd5, 3'd6, 3'd7};
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t2_id",   int'(id0), c % 4);
      chk("t2_data", int'(d0),  exp2[c]);
    end

    // Fairness: after 2 wins, requester 0 beats 2
    req0 = 4'b0100; step();
    req0 = 4'b0101; step(); chk("t3_id_a", int'(id0), 0);
    req0 = 4'b0100; step(); chk("t3_id_b", int'(id0), 2);
    req0 = '0;

    // Custom INIT on the 3-requester instance
    req1 = 3'b001; idx1 = '0; step(); chk("t4_data", int'(d1), 15);
    req1 = '0; step();
    chk("t4_idle_valid", int'(rv1), 0);
    chk("t4_hold_data",  int'(d1),  15);

    // Reset mid-stream
    req0 = 4'hF; step();
    rst = 1'b1; step(); chk("t5_valid", int'(rv0), 0);
    rst = 1'b0; step(); chk("t5_first", int'(id0), 0);
    req0 = '0;

`ifdef ARRAY_TABLE_WRITE_EN
    // Read-before-write, then new value, then reset restores INIT
    req0 = 4'b0010; idx0 = 12'(3 << 3);
    wr_en = 1'b1; wr_idx = 3'd3; wr_data = 4'hA;
    step(); chk("t6_old", int'(d0), 3);
    wr_en = 1'b0;
    step(); chk("t6_new", int'(d0), 10);
    rst = 1'b1; step(); rst = 1'b0;
    step(); chk("t6_reset", int'(d0), 3);
    req0 = '0;
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 31) == 0);
      req0 = N0'($urandom);
      idx0 = (3*N0)'($urandom);
      req1 = N1'($urandom);
      idx1 = (3*N1)'($urandom);
`ifdef ARRAY_TABLE_WRITE_EN
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_idx  = 3'($urandom);
      wr_data = 4'($urandom);
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
